// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx requester arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ARB,
        LAUNCH,
        WAIT_DONE,
        HOLD
    } arb_state_t;

    localparam int DATA_W_DEFAULT = 8;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping past N_REQ-1 back to 0.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int GW    = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [GW-1:0]    ptr_i,
    output logic [GW-1:0]    grant_o,
    output logic             any_req_o
);

    logic [GW:0] sum;

    // Scan offsets high to low so the smallest offset from ptr wins.
    always_comb begin
        grant_o   = ptr_i;
        any_req_o = 1'b0;
        sum       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + (GW + 1)'(k);
            if (sum >= (GW + 1)'(N_REQ)) begin
                sum = sum - (GW + 1)'(N_REQ);
            end
            if (req_i[sum[GW-1:0]]) begin
                grant_o   = sum[GW-1:0];
                any_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte requesters,
// with optional per-message locking and a stalled-lock timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int N_REQ        = 4,
    parameter  int DATA_W       = DATA_W_DEFAULT,
    parameter  int LOCK_TIMEOUT = 1_000_000,
    localparam int GW           = clog2_min1(N_REQ),
    localparam int CW           = $clog2(LOCK_TIMEOUT + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_busy,
    output logic [GW-1:0]           grant_id,
    output logic                    locked,
    output logic                    lock_timeout
);

    arb_state_t        state_q, state_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              pend_q, pend_d;
    logic              locked_q, locked_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [GW-1:0]     pick_idx;
    logic              pick_any;
    logic [GW-1:0]     sel;
    logic              accept;
    logic              expire;
    logic [GW-1:0]     ptr_next;

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .grant_o   (pick_idx),
        .any_req_o (pick_any)
    );

    assign ptr_next = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            pend_q   <= 1'b0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            pend_q   <= pend_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        pend_d   = pend_q;
        locked_d = locked_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ARB: ;
            LAUNCH: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (pend_q) begin
                        locked_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = HOLD;
                    end else begin
                        locked_d = 1'b0;
                        rr_ptr_d = ptr_next;
                        state_d  = ARB;
                    end
                end
            end
            HOLD: begin
                if (expire) begin
                    locked_d = 1'b0;
                    rr_ptr_d = ptr_next;
                    state_d  = ARB;
                end else if (!accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
        // Acceptance only arises in ARB or HOLD and always launches a byte.
        if (accept) begin
            state_d = LAUNCH;
            grant_d = sel;
            data_d  = req_data[int'(sel)*DATA_W +: DATA_W];
            pend_d  = ~req_last[sel];
        end
    end

    always_comb begin
        sel          = grant_q;
        accept       = 1'b0;
        expire       = 1'b0;
        tx_start     = 1'b0;
        lock_timeout = 1'b0;
        unique case (state_q)
            ARB: begin
                sel    = pick_idx;
                accept = pick_any & ~tx_busy;
            end
            LAUNCH: tx_start = 1'b1;
            WAIT_DONE: ;
            HOLD: begin
                expire       = (cnt_q == CW'(LOCK_TIMEOUT - 1));
                accept       = ~expire & req_valid[grant_q];
                lock_timeout = expire;
            end
            default: ;
        endcase
        req_ready = (accept & ~rst) ? (N_REQ'(1) << sel) : '0;
    end

    assign tx_data  = data_q;
    assign grant_id = grant_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter with a uart_tx stub
// and a message-level round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int LT    = 100;
    localparam int BDLY  = 5;
    localparam int FRAME = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          tx_busy;
    logic [1:0]    grant_id;
    logic          locked;
    logic          lock_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ        (N),
        .DATA_W       (DW),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .grant_id     (grant_id),
        .locked       (locked),
        .lock_timeout (lock_timeout)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [8:0]    rq [N][$];
    logic [DW-1:0] exp_tx [$];
    int            glog [$];
    int            m_ptr = 0;
    int            m_owner = -1;
    logic [N-1:0]  acc = '0;
    int            hold_cnt = 0;
    int            start_run = 0;
    int            n_timeouts = 0;
    int            n_sent = 0;
    int            n_acc = 0;
    int            gid_pend = 0;
    bit            gid_chk = 0;
    bit            busy_prev = 0;
    int            s_dly = 0;
    int            s_frame = 0;
    int            force_busy = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic last);
        rq[i].push_back({last, d});
    endtask

    task automatic monitor();
        int g;
        logic [N-1:0] oh;
        if (rst) begin
            acc = '0;
            hold_cnt = 0;
            start_run = 0;
            gid_chk = 0;
            busy_prev = 0;
            return;
        end
        if (gid_chk) begin
            chk("grant_id", grant_id, gid_pend);
            gid_chk = 0;
        end
        if (tx_start) begin
            start_run++;
        end else if (start_run != 0) begin
            chk("start_len", start_run, BDLY);
            start_run = 0;
        end
        if (!locked || tx_busy || tx_start || req_ready != 0 || busy_prev)
            hold_cnt = 0;
        else
            hold_cnt++;
        if (lock_timeout) begin
            chk("to_cycles", hold_cnt, LT);
            chk("to_owner", m_owner >= 0, 1);
            if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
            m_owner = -1;
            n_timeouts++;
        end
        acc = '0;
        if (req_ready != 0) begin
            if (m_owner >= 0) begin
                g = m_owner;
            end else begin
                g = -1;
                for (int k = N - 1; k >= 0; k--)
                    if (req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            if (g < 0) begin
                chk("spurious_ready", req_ready, 0);
            end else begin
                oh = '0;
                oh[g] = 1'b1;
                chk("grant", req_ready, oh);
                acc = req_ready & req_valid;
                n_acc++;
                exp_tx.push_back(rq[g][0][7:0]);
                glog.push_back(g);
                gid_pend = g;
                gid_chk = 1;
                if (rq[g][0][8]) begin
                    m_ptr = (g + 1) % N;
                    m_owner = -1;
                end else begin
                    m_owner = g;
                end
            end
        end
        busy_prev = tx_busy;
    endtask

    // uart_tx stand-in: raises busy BDLY cycles after start, for FRAME cycles.
    task automatic stub_tick();
        if (rst) begin
            tx_busy = 1'b0;
            s_dly = 0;
            s_frame = 0;
            return;
        end
        if (force_busy > 0) begin
            tx_busy = 1'b1;
            force_busy--;
            if (force_busy == 0) tx_busy = 1'b0;
            return;
        end
        if (!tx_busy) begin
            if (tx_start) begin
                if (s_dly == BDLY - 1) begin
                    tx_busy = 1'b1;
                    s_frame = FRAME;
                    s_dly = 0;
                    n_sent++;
                    if (exp_tx.size() == 0)
                        chk("tx_extra", exp_tx.size(), 1);
                    else
                        chk("tx_byte", tx_data, exp_tx.pop_front());
                end else begin
                    s_dly++;
                end
            end else begin
                s_dly = 0;
            end
        end else begin
            s_frame--;
            if (s_frame == 0) tx_busy = 1'b0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++)
            if (acc[i] && rq[i].size() > 0) rq[i].delete(0);
        acc = '0;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_data[i*DW +: DW] = rq[i][0][7:0];
                req_last[i] = rq[i][0][8];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*DW +: DW] = '0;
                req_last[i] = 1'b0;
            end
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        monitor();
    endtask

    task automatic at_tick();
        @(posedge clk);
        #1;
        stub_tick();
        drive();
    endtask

    task automatic cyc();
        at_tick();
        at_neg();
    endtask

    function automatic bit idle();
        bit e = 1;
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) e = 0;
        return e && exp_tx.size() == 0 && !tx_busy && !tx_start &&
               !locked && req_ready == 0;
    endfunction

    task automatic drain(input int budget);
        bit done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            cyc();
            done = idle();
        end
        chk("drain", done, 1);
    endtask

    task automatic chk_order(input string tag, input int exp[$]);
        chk({tag, "_len"}, glog.size(), exp.size());
        for (int k = 0; k < exp.size() && k < glog.size(); k++)
            chk(tag, glog[k], exp[k]);
    endtask

    initial begin
        int len;
        bit stall;
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        tx_busy = 1'b0;

        at_tick();
        at_neg();
        chk("rst_ready", req_ready, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_locked", locked, 0);
        chk("rst_timeout", lock_timeout, 0);
        at_tick();
        rst = 1'b0;
        at_neg();

        // busy already high after reset holds off the grant
        force_busy = 6;
        push(0, 8'h55, 1'b1);
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("busy_delay", req_ready, 0);
        end
        cyc();
        chk("busy_grant", req_ready, 4'b0001);
        drain(200);

        // single byte, latency and registered data
        push(1, 8'hA5, 1'b1);
        cyc();
        chk("t1_ready", req_ready, 4'b0010);
        chk("t1_start_early", tx_start, 0);
        cyc();
        chk("t1_start", tx_start, 1);
        chk("t1_gid", grant_id, 1);
        chk("t1_data", tx_data, 8'hA5);
        chk("t1_locked", locked, 0);
        drain(200);

        // pointer wraps from 3 back to 0
        glog.delete();
        push(3, 8'h77, 1'b1);
        drain(200);
        chk_order("wrap", '{3});

        for (int r = 0; r < 2; r++) begin
            glog.delete();
            for (int i = 0; i < N; i++) push(i, 8'(8'h10 + i), 1'b1);
            drain(400);
            chk_order("rr", '{0, 1, 2, 3});
        end

        // locked message from requester 2 is not interleaved
        push(1, 8'h21, 1'b1);
        drain(200);
        glog.delete();
        push(0, 8'h30, 1'b1);
        push(2, 8'h4F, 1'b0);
        push(2, 8'h4B, 1'b0);
        push(2, 8'h0A, 1'b1);
        push(3, 8'h33, 1'b1);
        drain(600);
        chk_order("lock", '{2, 2, 2, 3, 0});

        // stalled lock is force-released, pending requester 2 then served
        glog.delete();
        n_timeouts = 0;
        push(1, 8'h99, 1'b0);
        push(2, 8'h42, 1'b1);
        drain(600);
        chk("to_count", n_timeouts, 1);
        chk_order("timeout", '{1, 2});

        // reset while the frame of 8'h3C is in flight
        push(0, 8'h3C, 1'b1);
        for (int c = 0; c < 50 && !tx_busy; c++) cyc();
        chk("t5_busy", tx_busy, 1);
        cyc();
        cyc();
        push(1, 8'h5A, 1'b1);
        cyc();
        at_tick();
        rst = 1'b1;
        tx_busy = 1'b0;
        #1;
        chk("t5_start", tx_start, 0);
        chk("t5_ready", req_ready, 0);
        chk("t5_locked", locked, 0);
        chk("t5_gid", grant_id, 0);
        m_ptr = 0;
        m_owner = -1;
        exp_tx.delete();
        at_neg();
        chk("t5_ready_hold", req_ready, 0);
        at_tick();
        rst = 1'b0;
        at_neg();
        chk("t5_regrant", req_ready, 4'b0010);
        drain(200);

        // randomized traffic, some messages stall mid-lock
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() == 0 && $urandom_range(0, 39) == 0) begin
                    len = int'($urandom_range(1, 3));
                    stall = ($urandom_range(0, 9) == 0);
                    for (int b = 0; b < len; b++)
                        push(i, 8'($urandom), (b == len - 1) && !stall);
                end
            end
            cyc();
        end
        drain(3000);
        chk("sent_vs_acc", n_sent, n_acc);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx instance among N_REQ byte-stream requesters, such as a debug console, status reporter or error logger.
- Round-robin arbitration; each transfer is one byte on a valid/ready handshake.
- Drives uart_tx start/data_in and tracks its busy output.
- An optional per-requester message lock (req_last) keeps multi-byte messages from interleaving.
- A lock timeout recovers from a requester that stalls mid-message.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must match uart_tx data_in.
- LOCK_TIMEOUT, 1_000_000, clk cycles allowed in HOLD before the lock is forcibly released.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  N_REQ  requester i has a byte on req_data[i].
- req_data  in  N_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  N_REQ  byte is the final byte of a message; 1 means single-byte, no lock.
- req_ready  out  N_REQ  one-hot, one-cycle pulse: byte accepted.
- tx_start  out  1  to uart_tx start.
- tx_data  out  DATA_W  to uart_tx data_in; registered.
- tx_busy  in  1  from uart_tx busy.
- grant_id  out  $clog2(N_REQ)  current or last granted requester.
- locked  out  1  a message lock is held.
- lock_timeout  out  1  one-cycle pulse when a lock is force-released.

Behaviour:
Reset:
- All outputs are 0, state = ARB, rr_ptr = 0, timeout counter = 0.
- Asserting rst mid-operation returns to ARB immediately; tx_start drops asynchronously.
- uart_tx shares rst.

Handshake rules:
- A requester holds req_valid, req_data and req_last stable until its req_ready pulse.
- A transfer occurs only on req_valid[i] & req_ready[i].

States:
- ARB
  - If tx_busy == 0 and any req_valid is set, pick the first set bit searching from rr_ptr upward with wrap.
  - In the same cycle: pulse req_ready[g], latch tx_data <= req_data[g], grant_id <= g, lock_pending <= ~req_last[g]; go to LAUNCH.
  - With no valid request, or with tx_busy == 1, stay in ARB.
- LAUNCH
  - Hold tx_start = 1 until tx_busy is sampled 1, then drop tx_start and go to WAIT_DONE.
  - Holding start (rather than pulsing it) tolerates uart_tx sampling start only on baud_tick.
- WAIT_DONE
  - Stay while tx_busy == 1.
  - On tx_busy == 0: if lock_pending, set locked = 1, clear the timeout counter and go to HOLD.
  - Otherwise set locked = 0, rr_ptr <= (grant_id+1) mod N_REQ and go to ARB.
- HOLD
  - Other requesters are ignored; only requester grant_id is served.
  - If req_valid[grant_id]: pulse req_ready[grant_id], latch data, lock_pending <= ~req_last[grant_id]; go to LAUNCH. locked stays 1 until the last byte completes.
  - Otherwise increment the counter. When it reaches LOCK_TIMEOUT-1: pulse lock_timeout, set locked = 0, rr_ptr <= grant_id+1, go to ARB.

Latency:
- From req_valid (state ARB, idle link) to tx_start is 1 cycle: ready and latch happen in the arbitration cycle, start is asserted the next cycle.
- Throughput is one byte per uart_tx frame plus 2 cycles.

Boundaries:
- All N_REQ requesting simultaneously: grants are fair, each served once per N_REQ messages.
- rr_ptr wraps from N_REQ-1 to 0.
- A req_valid dropped before ready is a protocol violation; behaviour is undefined and there is no check.
- tx_busy already high on entry to ARB (after reset) delays the grant.
- A request arriving in the same cycle as a timeout expiry is not accepted; expiry wins.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum arb_state_t {ARB, LAUNCH, WAIT_DONE, HOLD};
  - DATA_W_DEFAULT = 8;
  - a function clog2_min1 for the grant_id width.
- One sub-module, uart_rr_pick: combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: grant index, any_req.
  - The arbiter FSM instantiates it once.

Test Plan:
1. Single byte: req_valid[1] = 1, data 8'hA5, last = 1 → ready[1] pulses the same cycle; tx_start is high the next cycle until busy is seen; the tx line carries A5; grant_id = 1; locked stays 0.
2. Round-robin: all 4 requesters hold single bytes 8'h10..8'h13 → service order 0, 1, 2, 3; rr_ptr then returns to 0. Re-asserting all four gives order 0, 1, 2, 3 again.
3. Message lock: req 2 sends 3 bytes "OK\n" (last on '\n') while req 0 and req 3 are valid → all three bytes from req 2 go out contiguously; then req 3 is served, then req 0.
4. Lock timeout (LOCK_TIMEOUT = 100): req 1 sends one byte with last = 0 and then goes idle → exactly 100 cycles after WAIT_DONE exits, lock_timeout pulses, locked = 0, and pending req 2 is granted.
5. Reset mid-frame: assert rst during WAIT_DONE of byte 8'h3C → tx_start = 0, req_ready = 0 and state = ARB immediately; after release, a new request is granted normally.
6. start/busy timing: a uart_tx stub that raises busy 5 cycles after start → tx_start is held for exactly those cycles and no byte is duplicated.
